// File: rtl/print_display_pkg.sv
// Shared constants and helpers for the print display unit: FSM encoding,
// active-low seven-segment codes and double-dabble helpers.
package print_display_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int NUM_DIGITS     = 8;
  localparam int SCRATCH_DIGITS = 10;

  typedef logic [3:0] bcd_digit_t;

  // Segment order {g,f,e,d,c,b,a}, a zero bit lights the segment
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [4*SCRATCH_DIGITS-1:0] dabble_adjust(
    input logic [4*SCRATCH_DIGITS-1:0] scratch
  );
    logic [4*SCRATCH_DIGITS-1:0] adj;
    adj = scratch;
    for (int i = 0; i < SCRATCH_DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = scratch[4*i +: 4];
      end
    end
    return adj;
  endfunction

  // A negative value gives up the top digit to the minus sign
  function automatic logic digits_overflow(
    input logic [4*SCRATCH_DIGITS-1:0] scratch,
    input logic                        neg
  );
    logic ovf;
    if (neg) begin
      ovf = |scratch[4*SCRATCH_DIGITS-1:28];
    end else begin
      ovf = |scratch[4*SCRATCH_DIGITS-1:32];
    end
    return ovf;
  endfunction

endpackage

// File: rtl/print_display_unit_seven_seg_digit.sv
// One BCD digit to active-low seven-segment decoder with a blank override;
// codes 10..15 decode to blank.
module seven_seg_digit
  import print_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Segment lookup
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/print_display_unit.sv
// Captures print_register on a print request, converts it to BCD with a
// sequential double-dabble engine and drives eight seven-segment displays.
module print_display_unit
  import print_display_pkg::*;
#(
  parameter bit SIGNED        = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        print,
  input  logic [31:0] print_register,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        negative,
  output logic [31:0] bcd,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  logic [1:0]  state_r;
  logic [31:0] value_r;
  logic [31:0] mag_r;
  logic [39:0] scratch_r;
  logic [4:0]  count_r;
  logic        neg_r;
  logic        busy_r;
  logic        done_r;
  logic        overflow_r;
  logic        negative_r;
  logic [31:0] bcd_r;

  logic [39:0] adj_s;
  logic        ovf_s;

  assign adj_s = dabble_adjust(scratch_r);
  assign ovf_s = digits_overflow(scratch_r, neg_r);

  // Control FSM and double-dabble datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      value_r    <= 32'd0;
      mag_r      <= 32'd0;
      scratch_r  <= 40'd0;
      count_r    <= 5'd0;
      neg_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      negative_r <= 1'b0;
      bcd_r      <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (print) begin
            value_r <= print_register;
            busy_r  <= 1'b1;
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (SIGNED && value_r[31]) begin
            mag_r <= ~value_r + 32'd1;
            neg_r <= 1'b1;
          end else begin
            mag_r <= value_r;
            neg_r <= 1'b0;
          end
          scratch_r <= 40'd0;
          count_r   <= 5'd0;
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Adjusted digits and magnitude shift left as one 72-bit word
          {scratch_r, mag_r} <= {adj_s[38:0], mag_r, 1'b0};
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r <= ST_FINISH;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_FINISH: begin
          overflow_r <= ovf_s;
          bcd_r      <= scratch_r[31:0];
          negative_r <= neg_r;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = overflow_r;
  assign negative = negative_r;
  assign bcd      = bcd_r;

  logic [7:0] blank_s;
  logic [6:0] seg_s [NUM_DIGITS];
  logic [6:0] hex_s [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_units
      assign blank_s[gi] = 1'b0;
    end else begin : g_upper
      // Blank when this digit and everything above it are zero
      assign blank_s[gi] = BLANK_LEADING && ~|bcd_r[31:4*gi];
    end
    seven_seg_digit u_digit (
      .digit (bcd_r[4*gi +: 4]),
      .blank (blank_s[gi]),
      .seg   (seg_s[gi])
    );
  end

  // Overflow and sign overrides on top of the decoded digits
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_s[i] = SEG_BLANK;
      if (overflow_r) begin
        hex_s[i] = SEG_MINUS;
      end else if ((i == NUM_DIGITS - 1) && negative_r) begin
        hex_s[i] = SEG_MINUS;
      end else begin
        hex_s[i] = seg_s[i];
      end
    end
  end

  assign HEX0 = hex_s[0];
  assign HEX1 = hex_s[1];
  assign HEX2 = hex_s[2];
  assign HEX3 = hex_s[3];
  assign HEX4 = hex_s[4];
  assign HEX5 = hex_s[5];
  assign HEX6 = hex_s[6];
  assign HEX7 = hex_s[7];

endmodule

// File: tb/tb_print_display_unit.sv
// Scoreboard bench for print_display_unit: a signed and an unsigned instance,
// expected displays computed arithmetically and compared on every done pulse.
module tb_print_display_unit;

  typedef struct packed {
    logic [31:0] bcd;
    logic        neg;
    logic        ovf;
    logic [55:0] hex;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        print = 1'b0;
  logic        print_u = 1'b0;
  logic [31:0] print_register = 32'd0;

  logic        busy, done, overflow, negative;
  logic [31:0] bcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        u_busy, u_done, u_overflow, u_negative;
  logic [31:0] u_bcd;
  logic [6:0]  u_hex0, u_hex1, u_hex2, u_hex3, u_hex4, u_hex5, u_hex6, u_hex7;
  logic [55:0] hex_all, u_hex_all;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int u_done_seen = 0;
  exp_t sb_q[$];
  exp_t sb_u_q[$];

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  assign hex_all   = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
  assign u_hex_all = {u_hex7, u_hex6, u_hex5, u_hex4, u_hex3, u_hex2, u_hex1, u_hex0};

  always #5 clk = ~clk;

  print_display_unit #(.SIGNED(1'b1), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .print(print), .print_register(print_register),
    .busy(busy), .done(done), .overflow(overflow), .negative(negative), .bcd(bcd),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
    .HEX4(hex4), .HEX5(hex5), .HEX6(hex6), .HEX7(hex7)
  );

  print_display_unit #(.SIGNED(1'b0), .BLANK_LEADING(1'b1)) dut_u (
    .clk(clk), .reset(reset), .print(print_u), .print_register(print_register),
    .busy(u_busy), .done(u_done), .overflow(u_overflow), .negative(u_negative), .bcd(u_bcd),
    .HEX0(u_hex0), .HEX1(u_hex1), .HEX2(u_hex2), .HEX3(u_hex3),
    .HEX4(u_hex4), .HEX5(u_hex5), .HEX6(u_hex6), .HEX7(u_hex7)
  );

  function automatic exp_t model(input logic [31:0] v, input bit sgn);
    exp_t e;
    logic [63:0] mag, tmp;
    logic [3:0] d [10];
    int msd;
    e.neg = sgn && v[31];
    mag = e.neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    tmp = mag;
    for (int i = 0; i < 10; i++) begin
      d[i] = 4'(tmp % 64'd10);
      tmp = tmp / 64'd10;
    end
    for (int i = 0; i < 8; i++) e.bcd[4*i +: 4] = d[i];
    e.ovf = e.neg ? (mag >= 64'd10000000) : (mag >= 64'd100000000);
    msd = 0;
    for (int i = 0; i < 8; i++) if (d[i] != 4'd0) msd = i;
    for (int i = 0; i < 8; i++) e.hex[7*i +: 7] = (i > msd) ? 7'h7F : seg_tab[d[i]];
    if (e.neg) e.hex[55:49] = 7'h3F;
    if (e.ovf) e.hex = {8{7'h3F}};
    return e;
  endfunction

  // Scoreboard: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_signed_empty: done pulse with no expected value, bcd=%h", bcd);
      end else begin
        e = sb_q.pop_front();
        if ({bcd, negative, overflow} !== {e.bcd, e.neg, e.ovf}) begin
          errors++;
          $display("FAIL sb_signed_value: bcd=%h neg=%b ovf=%b, expected bcd=%h neg=%b ovf=%b",
                   bcd, negative, overflow, e.bcd, e.neg, e.ovf);
        end
        checks++;
        if (hex_all !== e.hex) begin
          errors++;
          $display("FAIL sb_signed_hex: got %h, expected %h", hex_all, e.hex);
        end
      end
    end
    if (u_done === 1'b1) begin
      u_done_seen++;
      checks++;
      if (sb_u_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unsigned_empty: done pulse with no expected value, bcd=%h", u_bcd);
      end else begin
        e = sb_u_q.pop_front();
        if ({u_bcd, u_negative, u_overflow} !== {e.bcd, e.neg, e.ovf}) begin
          errors++;
          $display("FAIL sb_unsigned_value: bcd=%h neg=%b ovf=%b, expected bcd=%h neg=%b ovf=%b",
                   u_bcd, u_negative, u_overflow, e.bcd, e.neg, e.ovf);
        end
        checks++;
        if (u_hex_all !== e.hex) begin
          errors++;
          $display("FAIL sb_unsigned_hex: got %h, expected %h", u_hex_all, e.hex);
        end
      end
    end
  end

  // Returns at the negedge of the first cycle after the sampling edge
  task automatic drive_print(input logic [31:0] v, input bit uinst, input bit push);
    @(negedge clk);
    print_register = v;
    if (uinst) print_u = 1'b1;
    else print = 1'b1;
    if (push) begin
      if (uinst) sb_u_q.push_back(model(v, 1'b0));
      else sb_q.push_back(model(v, 1'b1));
    end
    @(posedge clk);
    @(negedge clk);
    print = 1'b0;
    print_u = 1'b0;
  endtask

  task automatic wait_done(input bit uinst, output int cyc, output bit found);
    found = 1'b0;
    cyc = 1;
    while (cyc <= 80) begin
      if ((uinst ? u_done : done) === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, overflow, negative} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/ovf/neg=%b, expected 0000", {busy, done, overflow, negative});
    end
    checks++;
    if (bcd !== 32'd0) begin
      errors++;
      $display("FAIL reset_bcd: got %h, expected 00000000", bcd);
    end
    checks++;
    if (hex_all !== {{7{7'h7F}}, 7'h40}) begin
      errors++;
      $display("FAIL reset_hex: got %h, expected %h", hex_all, {{7{7'h7F}}, 7'h40});
    end
    checks++;
    if ({u_busy, u_done, u_bcd, u_hex_all} !== {2'b00, 32'd0, {7{7'h7F}}, 7'h40}) begin
      errors++;
      $display("FAIL reset_unsigned: busy=%b done=%b bcd=%h hex=%h", u_busy, u_done, u_bcd, u_hex_all);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    bit found;
    drive_print(32'd1234, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_load: got %b, expected 1", busy);
    end
    wait_done(1'b0, cyc, found);
    checks++;
    if (!found || cyc != 35) begin
      errors++;
      $display("FAIL basic_latency: done at cycle %0d (found=%b), expected 35", cyc, found);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_done: got %b, expected 0", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got %b one cycle later, expected 0", done);
    end
  endtask

  task automatic test_negative();
    int cyc;
    bit found;
    drive_print(32'hFFFFFFFB, 1'b0, 1'b1);
    wait_done(1'b0, cyc, found);
    repeat (5) @(negedge clk);
    checks++;
    if (!found || hex7 !== 7'h3F || hex0 !== 7'h12 || negative !== 1'b1) begin
      errors++;
      $display("FAIL negative_hold: found=%b hex7=%h hex0=%h neg=%b, expected 1 3f 12 1",
               found, hex7, hex0, negative);
    end
  endtask

  task automatic test_boundaries();
    int cyc;
    bit found;
    logic [31:0] vals [6] = '{32'd99999999, 32'd100000000, 32'd0,
                              32'hFFFFFFFF, 32'hFF676981, 32'hFF676980};
    for (int i = 0; i < 6; i++) begin
      drive_print(vals[i], 1'b0, 1'b1);
      wait_done(1'b0, cyc, found);
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL boundary_timeout: value %h got no done, expected one", vals[i]);
      end
    end
  endtask

  task automatic test_min_signed();
    int cyc;
    bit found;
    drive_print(32'h80000000, 1'b0, 1'b1);
    wait_done(1'b0, cyc, found);
    drive_print(32'h80000000, 1'b1, 1'b1);
    wait_done(1'b1, cyc, found);
    checks++;
    if (!found || cyc != 35 || u_bcd !== 32'h47483648 || u_overflow !== 1'b1) begin
      errors++;
      $display("FAIL min_unsigned: found=%b cyc=%0d bcd=%h ovf=%b, expected 1 35 47483648 1",
               found, cyc, u_bcd, u_overflow);
    end
    drive_print(32'hFFFFFFFF, 1'b1, 1'b1);
    wait_done(1'b1, cyc, found);
  endtask

  task automatic test_ignored_print();
    int cyc;
    bit found;
    int base;
    base = done_seen;
    drive_print(32'd777, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    print_register = 32'd555;
    print = 1'b1;
    @(negedge clk);
    print = 1'b0;
    wait_done(1'b0, cyc, found);
    repeat (45) @(negedge clk);
    checks++;
    if (done_seen != base + 1 || bcd !== 32'h00000777) begin
      errors++;
      $display("FAIL ignored_print: done pulses=%0d bcd=%h, expected 1 00000777", done_seen - base, bcd);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit found;
    int base;
    drive_print(32'd4321, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    base = done_seen;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bcd !== 32'd0 || hex0 !== 7'h40) begin
      errors++;
      $display("FAIL reset_mid: busy=%b bcd=%h hex0=%h, expected 0 00000000 40", busy, bcd, hex0);
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (done_seen != base) begin
      errors++;
      $display("FAIL reset_mid_done: %0d done pulses after reset, expected 0", done_seen - base);
    end
    drive_print(32'd2024, 1'b0, 1'b1);
    wait_done(1'b0, cyc, found);
    checks++;
    if (!found || cyc != 35) begin
      errors++;
      $display("FAIL reset_mid_next: done at cycle %0d (found=%b), expected 35", cyc, found);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit found;
    @(negedge clk);
    print_register = 32'd31415926;
    print = 1'b1;
    sb_q.push_back(model(32'd31415926, 1'b1));
    @(posedge clk);
    @(negedge clk);
    wait_done(1'b0, cyc, found);
    print_register = 32'd27182818;
    sb_q.push_back(model(32'd27182818, 1'b1));
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_capture: busy=%b after done with print held, expected 1", busy);
    end
    print = 1'b0;
    wait_done(1'b0, cyc, found);
    checks++;
    if (!found || cyc != 35) begin
      errors++;
      $display("FAIL back_to_back_latency: done at cycle %0d (found=%b), expected 35", cyc, found);
    end
  endtask

  task automatic test_random();
    int cyc;
    bit found;
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      v = (i % 2 == 0) ? 32'($urandom_range(0, 99999999)) : 32'($urandom);
      drive_print(v, i[1], 1'b1);
      wait_done(i[1], cyc, found);
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL random_timeout: value %h got no done, expected one", v);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_boundaries();
    test_min_signed();
    test_ignored_print();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (5) @(negedge clk);
    checks++;
    if (sb_q.size() != 0 || sb_u_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d/%0d expectations unmatched, expected 0/0", sb_q.size(), sb_u_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
